// File: rtl/ether_pkg.sv
// Shared constants and types for the Ethernet receive path.
// CRC constants are in reflected (LSB-first) form.
package ether_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_SEED      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int unsigned DEF_MIN_BYTES = 64;
    localparam int unsigned DEF_MAX_BYTES = 1518;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fcs_state_e;

endpackage

// File: rtl/fcs_check_if.sv
// Beat stream into the FCS checker and the per-frame status / counters it returns.
interface fcs_check_if #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) ();

    logic                  axiiv;
    logic [DATA_WIDTH-1:0] axiid;

    logic                  done;
    logic                  kill;
    logic                  status_valid;
    logic                  crc_err;
    logic                  runt;
    logic                  giant;
    logic                  align_err;
    logic [CNT_WIDTH-1:0]  frame_bytes;
    logic [CNT_WIDTH-1:0]  good_count;
    logic [CNT_WIDTH-1:0]  bad_count;

    modport master (
        output axiiv, axiid,
        input  done, kill, status_valid, crc_err, runt, giant, align_err,
        input  frame_bytes, good_count, bad_count
    );

    modport slave (
        input  axiiv, axiid,
        output done, kill, status_valid, crc_err, runt, giant, align_err,
        output frame_bytes, good_count, bad_count
    );

endinterface

// File: rtl/crc32_step.sv
// Combinational reflected CRC-32 update folding DATA_WIDTH bits, data[0] first.
module crc32_step
    import ether_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic [31:0]           crc_in,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ data[i]) ? CRC32_POLY_REFL : '0);
        end
    end

endmodule

// File: rtl/fcs_check.sv
// Ethernet FCS, length and byte-alignment checker on the post-SFD beat stream.
// Produces sticky per-frame status and saturating good/bad frame counters.
module fcs_check
    import ether_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned MIN_BYTES  = DEF_MIN_BYTES,
    parameter int unsigned MAX_BYTES  = DEF_MAX_BYTES,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic        clk,
    input logic        rst,
    fcs_check_if.slave bus
);

    if (DATA_WIDTH != 2 && DATA_WIDTH != 8) begin : g_bad_width
        $error("fcs_check: DATA_WIDTH must be 2 or 8");
    end

    localparam int unsigned BEATS_PER_BYTE = 8 / DATA_WIDTH;
    localparam int unsigned SHIFT          = $clog2(BEATS_PER_BYTE);
    localparam int unsigned BEAT_LIMIT     = (MAX_BYTES + 1) * BEATS_PER_BYTE;
    localparam int unsigned BW_LEN         = $clog2(BEAT_LIMIT + 1);
    localparam int unsigned BW_CNT         = CNT_WIDTH + SHIFT + 1;
    // Wide enough that a saturated beat count always reads as giant and
    // frame_bytes saturation can be detected from the upper bits.
    localparam int unsigned BEAT_W         = (BW_LEN > BW_CNT) ? BW_LEN : BW_CNT;
    localparam logic [BEAT_W-1:0] ALIGN_MASK = BEAT_W'(BEATS_PER_BYTE - 1);

    fcs_state_e state_q, state_d;
    logic       first_beat, next_beat, eval;

    logic [31:0]       crc_q, crc_prev, crc_next;
    logic [BEAT_W-1:0] beats_q, bytes_full;

    logic                 crc_err_d, runt_d, giant_d, align_err_d, kill_d;
    logic [CNT_WIDTH-1:0] frame_bytes_d;

    logic                 done_q, kill_q, status_valid_q;
    logic                 crc_err_q, runt_q, giant_q, align_err_q;
    logic [CNT_WIDTH-1:0] frame_bytes_q, good_q, bad_q;

    // First beat restarts from the seed so back-to-back frames need no clear cycle.
    assign crc_prev = (state_q == ST_RUN) ? crc_q : CRC32_SEED;

    crc32_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .crc_in (crc_prev),
        .data   (bus.axiid),
        .crc_out(crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_beat = 1'b0;
        next_beat  = 1'b0;
        eval       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.axiiv) begin
                    state_d    = ST_RUN;
                    first_beat = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.axiiv) begin
                    next_beat = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    eval    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus.axiiv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_DRAIN;
        endcase
    end

    always_comb begin
        bytes_full    = beats_q >> SHIFT;
        align_err_d   = |(beats_q & ALIGN_MASK);
        runt_d        = bytes_full < BEAT_W'(MIN_BYTES);
        giant_d       = bytes_full > BEAT_W'(MAX_BYTES);
        crc_err_d     = crc_q != CRC32_RESIDUE;
        kill_d        = crc_err_d | runt_d | giant_d | align_err_d;
        frame_bytes_d = (|bytes_full[BEAT_W-1:CNT_WIDTH]) ? '1 : bytes_full[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q          <= CRC32_SEED;
            beats_q        <= '0;
            done_q         <= 1'b0;
            kill_q         <= 1'b0;
            status_valid_q <= 1'b0;
            crc_err_q      <= 1'b0;
            runt_q         <= 1'b0;
            giant_q        <= 1'b0;
            align_err_q    <= 1'b0;
            frame_bytes_q  <= '0;
            good_q         <= '0;
            bad_q          <= '0;
        end else begin
            status_valid_q <= 1'b0;
            if (first_beat) begin
                crc_q       <= crc_next;
                beats_q     <= BEAT_W'(1);
                done_q      <= 1'b0;
                kill_q      <= 1'b0;
                crc_err_q   <= 1'b0;
                runt_q      <= 1'b0;
                giant_q     <= 1'b0;
                align_err_q <= 1'b0;
            end else if (next_beat) begin
                crc_q <= crc_next;
                if (beats_q != '1) begin
                    beats_q <= beats_q + BEAT_W'(1);
                end
            end else if (eval) begin
                done_q         <= 1'b1;
                status_valid_q <= 1'b1;
                kill_q         <= kill_d;
                crc_err_q      <= crc_err_d;
                runt_q         <= runt_d;
                giant_q        <= giant_d;
                align_err_q    <= align_err_d;
                frame_bytes_q  <= frame_bytes_d;
                if (kill_d) begin
                    if (bad_q != '1) begin
                        bad_q <= bad_q + CNT_WIDTH'(1);
                    end
                end else if (good_q != '1) begin
                    good_q <= good_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.done         = done_q;
    assign bus.kill         = kill_q;
    assign bus.status_valid = status_valid_q;
    assign bus.crc_err      = crc_err_q;
    assign bus.runt         = runt_q;
    assign bus.giant        = giant_q;
    assign bus.align_err    = align_err_q;
    assign bus.frame_bytes  = frame_bytes_q;
    assign bus.good_count   = good_q;
    assign bus.bad_count    = bad_q;

endmodule

// File: tb/tb_fcs_check.sv
// Bench for fcs_check: dibit, byte and narrow-counter instances against a
// frame-level model (FCS field vs. CRC-32 of the payload, length rules, counters).
module tb_fcs_check;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fcs_check_if #(.DATA_WIDTH(2), .CNT_WIDTH(16)) bus2 ();
    fcs_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus8 ();
    fcs_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  buss ();

    fcs_check #(.DATA_WIDTH(2), .MIN_BYTES(64), .MAX_BYTES(1518), .CNT_WIDTH(16))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    fcs_check #(.DATA_WIDTH(8), .MIN_BYTES(64), .MAX_BYTES(1518), .CNT_WIDTH(16))
        u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    fcs_check #(.DATA_WIDTH(8), .MIN_BYTES(4), .MAX_BYTES(8), .CNT_WIDTH(4))
        u_duts (.clk(clk), .rst(rst), .bus(buss.slave));

    typedef struct {
        logic        dn, kl, sv, ce, rn, gi, al;
        logic [31:0] fb, gc, bc;
    } obs_t;

    typedef struct {
        logic        ce, rn, gi, al, kl;
        logic [31:0] fb;
    } exp_t;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    bit          frm[$];
    obs_t        obs;
    exp_t        exp_cur;
    int unsigned minb [3] = '{64, 64, 4};
    int unsigned maxb [3] = '{1518, 1518, 8};
    int unsigned cmax [3] = '{65535, 65535, 15};
    int unsigned gcnt [3] = '{0, 0, 0};
    int unsigned bcnt [3] = '{0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Standard Ethernet CRC-32 over the first nbytes of frm, final complement applied.
    function automatic logic [31:0] crc32_bytes(input int unsigned nbytes);
        logic [31:0] c;
        bit          fb;
        c = 32'hFFFFFFFF;
        for (int unsigned i = 0; i < nbytes; i++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                fb = c[0] ^ frm[8*i+j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic mk_frame(input int unsigned nbytes);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        for (int unsigned i = 0; i + 4 < nbytes; i++) begin
            b = 8'($urandom());
            for (int unsigned j = 0; j < 8; j++) frm.push_back(b[j]);
        end
        c = crc32_bytes(nbytes - 4);
        for (int unsigned j = 0; j < 32; j++) frm.push_back(c[j]);
    endtask

    task automatic predict(input int inst);
        int unsigned nb, by;
        logic [31:0] fcs;
        logic        ok;
        nb = frm.size();
        by = nb / 8;
        ok = 1'b0;
        exp_cur.al = (nb % 8) != 0;
        exp_cur.rn = by < minb[inst];
        exp_cur.gi = by > maxb[inst];
        if (!exp_cur.al && by >= 4) begin
            for (int unsigned k = 0; k < 32; k++) fcs[k] = frm[nb-32+k];
            ok = (fcs == crc32_bytes(by - 4));
        end
        exp_cur.ce = !ok;
        exp_cur.kl = exp_cur.ce | exp_cur.rn | exp_cur.gi | exp_cur.al;
        exp_cur.fb = (by > cmax[inst]) ? cmax[inst] : by;
        if (exp_cur.kl) begin
            if (bcnt[inst] < cmax[inst]) bcnt[inst]++;
        end else if (gcnt[inst] < cmax[inst]) begin
            gcnt[inst]++;
        end
    endtask

    task automatic read_out(input int inst);
        case (inst)
            0: obs = '{bus2.done, bus2.kill, bus2.status_valid, bus2.crc_err, bus2.runt,
                       bus2.giant, bus2.align_err, 32'(bus2.frame_bytes),
                       32'(bus2.good_count), 32'(bus2.bad_count)};
            1: obs = '{bus8.done, bus8.kill, bus8.status_valid, bus8.crc_err, bus8.runt,
                       bus8.giant, bus8.align_err, 32'(bus8.frame_bytes),
                       32'(bus8.good_count), 32'(bus8.bad_count)};
            default: obs = '{buss.done, buss.kill, buss.status_valid, buss.crc_err, buss.runt,
                             buss.giant, buss.align_err, 32'(buss.frame_bytes),
                             32'(buss.good_count), 32'(buss.bad_count)};
        endcase
    endtask

    task automatic check_status(input int inst, input string tag);
        read_out(inst);
        chk({tag, ".done"},  32'(obs.dn), 32'd1);
        chk({tag, ".sv"},    32'(obs.sv), 32'd1);
        chk({tag, ".kill"},  32'(obs.kl), 32'(exp_cur.kl));
        chk({tag, ".crc"},   32'(obs.ce), 32'(exp_cur.ce));
        chk({tag, ".runt"},  32'(obs.rn), 32'(exp_cur.rn));
        chk({tag, ".giant"}, 32'(obs.gi), 32'(exp_cur.gi));
        chk({tag, ".align"}, 32'(obs.al), 32'(exp_cur.al));
        chk({tag, ".bytes"}, obs.fb, exp_cur.fb);
        chk({tag, ".good"},  obs.gc, gcnt[inst]);
        chk({tag, ".bad"},   obs.bc, bcnt[inst]);
    endtask

    task automatic drive_beats(input int inst, input int unsigned first, input int unsigned last);
        logic [7:0]  b;
        int unsigned w;
        w = (inst == 0) ? 2 : 8;
        for (int unsigned k = first; k < last; k++) begin
            b = '0;
            for (int unsigned j = 0; j < w; j++) b[j] = frm[k*w+j];
            case (inst)
                0:       begin bus2.axiiv = 1'b1; bus2.axiid = b[1:0]; end
                1:       begin bus8.axiiv = 1'b1; bus8.axiid = b; end
                default: begin buss.axiiv = 1'b1; buss.axiid = b; end
            endcase
            tick();
        end
    endtask

    task automatic end_frame(input int inst);
        case (inst)
            0:       bus2.axiiv = 1'b0;
            1:       bus8.axiiv = 1'b0;
            default: buss.axiiv = 1'b0;
        endcase
        tick();
    endtask

    function automatic int unsigned nbeats(input int inst);
        return (inst == 0) ? frm.size() / 2 : frm.size() / 8;
    endfunction

    task automatic run_frame(input int inst, input string tag);
        drive_beats(inst, 0, nbeats(inst));
        end_frame(inst);
        predict(inst);
        check_status(inst, tag);
        tick();
        read_out(inst);
        chk({tag, ".sv_drop"},   32'(obs.sv), 32'd0);
        chk({tag, ".done_held"}, 32'(obs.dn), 32'd1);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 3; i++) begin
            gcnt[i] = 0;
            bcnt[i] = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n, idx;
        rst = 1'b1;
        bus2.axiiv = 1'b0; bus2.axiid = '0;
        bus8.axiiv = 1'b0; bus8.axiid = '0;
        buss.axiiv = 1'b0; buss.axiid = '0;
        repeat (3) tick();

        read_out(0);
        chk("rst.done",  32'(obs.dn), 32'd0);
        chk("rst.kill",  32'(obs.kl), 32'd0);
        chk("rst.sv",    32'(obs.sv), 32'd0);
        chk("rst.crc",   32'(obs.ce), 32'd0);
        chk("rst.bytes", obs.fb, 32'd0);
        chk("rst.good",  obs.gc, 32'd0);
        chk("rst.bad",   obs.bc, 32'd0);
        read_out(2);
        chk("rst.s_good", obs.gc, 32'd0);

        rst = 1'b0;
        tick();

        mk_frame(64);
        run_frame(0, "good64");
        frm[100] = ~frm[100];
        run_frame(0, "flip");
        mk_frame(60);
        run_frame(0, "runt60");
        mk_frame(1519);
        run_frame(0, "giant1519");
        mk_frame(64);
        frm.push_back(1'($urandom()));
        frm.push_back(1'($urandom()));
        run_frame(0, "align257");
        mk_frame(4);
        frm = frm[0:7];
        run_frame(0, "onebyte");

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(58, 70);
            mk_frame(n);
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 8 * (n - 4) - 1);
                frm[idx] = ~frm[idx];
            end
            run_frame(0, "rand2");
        end

        // Back-to-back byte frames with a single idle cycle between them.
        mk_frame($urandom_range(64, 90));
        drive_beats(1, 0, nbeats(1));
        end_frame(1);
        predict(1);
        check_status(1, "b2b_1");
        mk_frame(72);
        drive_beats(1, 0, 1);
        read_out(1);
        chk("b2b.done_low", 32'(obs.dn), 32'd0);
        chk("b2b.sv_low",   32'(obs.sv), 32'd0);
        chk("b2b.kill_low", 32'(obs.kl), 32'd0);
        drive_beats(1, 1, nbeats(1));
        end_frame(1);
        predict(1);
        check_status(1, "b2b_2");
        chk("b2b.good2", obs.gc, 32'd2);

        // Reset mid-frame with valid held high afterwards: partial frame is discarded.
        mk_frame(64);
        drive_beats(0, 0, 100);
        rst = 1'b1;
        drive_beats(0, 100, 102);
        rst = 1'b0;
        drive_beats(0, 102, 256);
        end_frame(0);
        zero_model();
        read_out(0);
        chk("midrst.done", 32'(obs.dn), 32'd0);
        chk("midrst.sv",   32'(obs.sv), 32'd0);
        chk("midrst.good", obs.gc, 32'(gcnt[0]));
        chk("midrst.bad",  obs.bc, 32'(bcnt[0]));
        read_out(1);
        chk("midrst.good8", obs.gc, 32'(gcnt[1]));
        tick();
        read_out(0);
        chk("midrst.sv_late", 32'(obs.sv), 32'd0);
        mk_frame(64);
        run_frame(0, "post_rst");

        // Reset coinciding with the evaluation edge suppresses the count.
        mk_frame(64);
        drive_beats(0, 0, 256);
        bus2.axiiv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        zero_model();
        read_out(0);
        chk("rstprio.done", 32'(obs.dn), 32'd0);
        chk("rstprio.sv",   32'(obs.sv), 32'd0);
        chk("rstprio.good", obs.gc, 32'(gcnt[0]));
        tick();
        mk_frame(68);
        run_frame(0, "after_prio");

        // Narrow-counter instance: independent saturation of both counters.
        for (int r = 0; r < 17; r++) begin
            mk_frame(4);
            frm = frm[0:7];
            run_frame(2, "sat_bad");
        end
        for (int r = 0; r < 17; r++) begin
            mk_frame($urandom_range(4, 8));
            run_frame(2, "sat_good");
        end
        mk_frame(20);
        run_frame(2, "sat_bytes");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
